// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants for the raster generator and every pixel consumer.
// Renderers should use the *_ACT_START values rather than literal sync+back-porch sums.
package vga_pkg;

  localparam int unsigned COUNT_W = 10;

  localparam int unsigned H_SYNC_LEN   = 96;
  localparam int unsigned H_BACK_LEN   = 48;
  localparam int unsigned H_ACTIVE_LEN = 640;
  localparam int unsigned H_FRONT_LEN  = 16;
  localparam int unsigned V_SYNC_LEN   = 2;
  localparam int unsigned V_BACK_LEN   = 33;
  localparam int unsigned V_ACTIVE_LEN = 480;
  localparam int unsigned V_FRONT_LEN  = 10;
  localparam int unsigned DEF_FRAME_W  = 8;

  function automatic int unsigned axis_total(input int unsigned sync_len,
                                             input int unsigned back_len,
                                             input int unsigned active_len,
                                             input int unsigned front_len);
    return sync_len + back_len + active_len + front_len;
  endfunction

  localparam int unsigned H_TOTAL     = axis_total(H_SYNC_LEN, H_BACK_LEN, H_ACTIVE_LEN, H_FRONT_LEN);
  localparam int unsigned V_TOTAL     = axis_total(V_SYNC_LEN, V_BACK_LEN, V_ACTIVE_LEN, V_FRONT_LEN);
  localparam int unsigned H_ACT_START = H_SYNC_LEN + H_BACK_LEN;
  localparam int unsigned H_ACT_END   = H_ACT_START + H_ACTIVE_LEN - 1;
  localparam int unsigned V_ACT_START = V_SYNC_LEN + V_BACK_LEN;
  localparam int unsigned V_ACT_END   = V_ACT_START + V_ACTIVE_LEN - 1;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bus: the generator drives position/sync/pulses, consumers supply pix_ce.
interface vga_timing_gen_if
  import vga_pkg::*;
#(
  parameter int unsigned FRAME_W = DEF_FRAME_W
);
  logic               pix_ce;
  logic [COUNT_W-1:0] h_count;
  logic [COUNT_W-1:0] v_count;
  logic               hsync;
  logic               vsync;
  logic               display_active;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;

  modport master (
    input  pix_ce,
    output h_count, v_count, hsync, vsync, display_active,
    output line_start, frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  h_count, v_count, hsync, vsync, display_active,
    input  line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with sync/active flags registered from the next count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned SYNC   = H_SYNC_LEN,
  parameter int unsigned BACK   = H_BACK_LEN,
  parameter int unsigned ACTIVE = H_ACTIVE_LEN,
  parameter int unsigned FRONT  = H_FRONT_LEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  output logic [COUNT_W-1:0] count,
  output logic               sync_n,
  output logic               active,
  output logic               active_next,
  output logic               wrap
);

  localparam int unsigned        TOTAL     = axis_total(SYNC, BACK, ACTIVE, FRONT);
  localparam logic [COUNT_W-1:0] LAST      = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] SYNC_END  = COUNT_W'(SYNC);
  localparam logic [COUNT_W-1:0] ACT_FIRST = COUNT_W'(SYNC + BACK);
  localparam logic [COUNT_W-1:0] ACT_LAST  = COUNT_W'(SYNC + BACK + ACTIVE - 1);

  logic [COUNT_W-1:0] count_q, count_d;
  logic               sync_n_q, sync_n_d;
  logic               active_q, active_d;

  // wrap is combinational so the next axis can step in the same cycle this one rolls over.
  always_comb begin
    count_d = count_q;
    wrap    = 1'b0;
    if (step) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + COUNT_W'(1);
      end
    end
    sync_n_d = (count_d >= SYNC_END);
    active_d = (count_d >= ACT_FIRST) && (count_d <= ACT_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      sync_n_q <= 1'b0;
      active_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      sync_n_q <= sync_n_d;
      active_q <= active_d;
    end
  end

  assign count       = count_q;
  assign sync_n      = sync_n_q;
  assign active      = active_q;
  assign active_next = active_d;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: chained horizontal/vertical counters plus line/frame pulses.
// Every output is a flop, so sync and active always line up with the presented position.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC   = H_SYNC_LEN,
  parameter int unsigned H_BACK   = H_BACK_LEN,
  parameter int unsigned H_ACTIVE = H_ACTIVE_LEN,
  parameter int unsigned H_FRONT  = H_FRONT_LEN,
  parameter int unsigned V_SYNC   = V_SYNC_LEN,
  parameter int unsigned V_BACK   = V_BACK_LEN,
  parameter int unsigned V_ACTIVE = V_ACTIVE_LEN,
  parameter int unsigned V_FRONT  = V_FRONT_LEN,
  parameter int unsigned FRAME_W  = DEF_FRAME_W
) (
  input  logic              clk,
  input  logic              rst,
  vga_timing_gen_if.master  bus
);

  logic [COUNT_W-1:0] h_count, v_count;
  logic               h_sync_n, v_sync_n;
  logic               h_active, v_active;
  logic               h_active_next, v_active_next;
  logic               h_wrap, v_wrap, v_step;

  logic               display_active_q, display_active_d;
  logic               line_start_q, line_start_d;
  logic               frame_start_q, frame_start_d;
  logic [FRAME_W-1:0] frame_count_q, frame_count_d;

  assign v_step = bus.pix_ce & h_wrap;

  vga_axis_counter #(
    .SYNC   (H_SYNC),
    .BACK   (H_BACK),
    .ACTIVE (H_ACTIVE),
    .FRONT  (H_FRONT)
  ) u_h_axis (
    .clk         (clk),
    .rst         (rst),
    .step        (bus.pix_ce),
    .count       (h_count),
    .sync_n      (h_sync_n),
    .active      (h_active),
    .active_next (h_active_next),
    .wrap        (h_wrap)
  );

  vga_axis_counter #(
    .SYNC   (V_SYNC),
    .BACK   (V_BACK),
    .ACTIVE (V_ACTIVE),
    .FRONT  (V_FRONT)
  ) u_v_axis (
    .clk         (clk),
    .rst         (rst),
    .step        (v_step),
    .count       (v_count),
    .sync_n      (v_sync_n),
    .active      (v_active),
    .active_next (v_active_next),
    .wrap        (v_wrap)
  );

  // Wrap flags only fire on a stepping cycle, so pulses drop to 0 whenever pix_ce is low.
  always_comb begin
    line_start_d     = h_wrap;
    frame_start_d    = h_wrap & v_wrap;
    display_active_d = h_active_next & v_active_next;
    frame_count_d    = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + FRAME_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      display_active_q <= 1'b0;
      line_start_q     <= 1'b0;
      frame_start_q    <= 1'b0;
      frame_count_q    <= '0;
    end else begin
      display_active_q <= display_active_d;
      line_start_q     <= line_start_d;
      frame_start_q    <= frame_start_d;
      frame_count_q    <= frame_count_d;
    end
  end

  assign bus.h_count        = h_count;
  assign bus.v_count        = v_count;
  assign bus.hsync          = h_sync_n;
  assign bus.vsync          = v_sync_n;
  assign bus.display_active = display_active_q;
  assign bus.line_start     = line_start_q;
  assign bus.frame_start    = frame_start_q;
  assign bus.frame_count    = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line/pix_ce/active-window checks, a shrunken
// instance (16x5 raster) for frame, mid-frame reset and frame_count wrap checks.
module tb_vga_timing_gen;
  import vga_pkg::*;

  localparam int S_HS = 4, S_HB = 2, S_HA = 8, S_HF = 2, S_HT = 16;
  localparam int S_VS = 1, S_VB = 1, S_VA = 2, S_VF = 1, S_VT = 5;
  localparam int S_FRAME = S_HT * S_VT;

  logic clk = 1'b0;
  logic rst_d = 1'b1;
  logic rst_s = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.FRAME_W(8)) bus_d ();
  vga_timing_gen_if #(.FRAME_W(8)) bus_s ();

  vga_timing_gen dut_d (
    .clk (clk),
    .rst (rst_d),
    .bus (bus_d)
  );

  vga_timing_gen #(
    .H_SYNC (S_HS), .H_BACK (S_HB), .H_ACTIVE (S_HA), .H_FRONT (S_HF),
    .V_SYNC (S_VS), .V_BACK (S_VB), .V_ACTIVE (S_VA), .V_FRONT (S_VF),
    .FRAME_W (8)
  ) dut_s (
    .clk (clk),
    .rst (rst_s),
    .bus (bus_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus_d.pix_ce = 1'b1;
    bus_s.pix_ce = 1'b1;
    rst_d = 1'b1;
    rst_s = 1'b1;
    tick();
    tick();
    checks++; if (bus_d.h_count !== 10'd0) begin errors++; $display("FAIL reset_h actual=%0d required=0", bus_d.h_count); end
    checks++; if (bus_d.v_count !== 10'd0) begin errors++; $display("FAIL reset_v actual=%0d required=0", bus_d.v_count); end
    checks++; if (bus_d.hsync !== 1'b0) begin errors++; $display("FAIL reset_hsync actual=%b required=0", bus_d.hsync); end
    checks++; if (bus_d.vsync !== 1'b0) begin errors++; $display("FAIL reset_vsync actual=%b required=0", bus_d.vsync); end
    checks++; if (bus_d.display_active !== 1'b0) begin errors++; $display("FAIL reset_da actual=%b required=0", bus_d.display_active); end
    checks++; if (bus_d.line_start !== 1'b0) begin errors++; $display("FAIL reset_ls actual=%b required=0", bus_d.line_start); end
    checks++; if (bus_d.frame_start !== 1'b0) begin errors++; $display("FAIL reset_fs actual=%b required=0", bus_d.frame_start); end
    checks++; if (bus_d.frame_count !== 8'd0) begin errors++; $display("FAIL reset_fc actual=%0d required=0", bus_d.frame_count); end
    checks++; if (bus_s.h_count !== 10'd0) begin errors++; $display("FAIL reset_small_h actual=%0d required=0", bus_s.h_count); end
    rst_d = 1'b0;
    rst_s = 1'b0;
    bus_d.pix_ce = 1'b0;
    bus_s.pix_ce = 1'b0;
    tick();
    checks++; if (bus_d.h_count !== 10'd0) begin errors++; $display("FAIL hold_h actual=%0d required=0", bus_d.h_count); end
    checks++; if (bus_d.frame_start !== 1'b0) begin errors++; $display("FAIL hold_fs actual=%b required=0", bus_d.frame_start); end
  endtask

  task automatic test_line();
    int   hs_low = 0;
    int   ls_cnt = 0;
    int   exp_h, exp_v;
    logic exp_hs, exp_ls;
    bus_d.pix_ce = 1'b1;
    for (int i = 1; i <= 800; i++) begin
      tick();
      exp_h  = i % 800;
      exp_v  = i / 800;
      exp_hs = (exp_h >= 96);
      exp_ls = (i == 800);
      if (bus_d.hsync === 1'b0) hs_low++;
      if (bus_d.line_start === 1'b1) ls_cnt++;
      checks++; if (bus_d.h_count !== 10'(exp_h)) begin errors++; $display("FAIL line_h i=%0d actual=%0d required=%0d", i, bus_d.h_count, exp_h); end
      checks++; if (bus_d.v_count !== 10'(exp_v)) begin errors++; $display("FAIL line_v i=%0d actual=%0d required=%0d", i, bus_d.v_count, exp_v); end
      checks++; if (bus_d.hsync !== exp_hs) begin errors++; $display("FAIL line_hsync i=%0d actual=%b required=%b", i, bus_d.hsync, exp_hs); end
      checks++; if (bus_d.vsync !== 1'b0) begin errors++; $display("FAIL line_vsync i=%0d actual=%b required=0", i, bus_d.vsync); end
      checks++; if (bus_d.line_start !== exp_ls) begin errors++; $display("FAIL line_ls i=%0d actual=%b required=%b", i, bus_d.line_start, exp_ls); end
    end
    checks++; if (hs_low != 96) begin errors++; $display("FAIL line_hsync_low_cycles actual=%0d required=96", hs_low); end
    checks++; if (ls_cnt != 1) begin errors++; $display("FAIL line_ls_pulses actual=%0d required=1", ls_cnt); end
    bus_d.pix_ce = 1'b0;
  endtask

  task automatic test_ce_toggle();
    int   exp_h = 0;
    int   exp_v = 1;
    int   ls_cnt = 0;
    logic ce, exp_ls, exp_hs;
    for (int i = 0; i < 1600; i++) begin
      ce = ((i % 2) == 0);
      bus_d.pix_ce = ce;
      tick();
      exp_ls = 1'b0;
      if (ce) begin
        if (exp_h == 799) begin
          exp_h  = 0;
          exp_v  = exp_v + 1;
          exp_ls = 1'b1;
        end else begin
          exp_h = exp_h + 1;
        end
      end
      exp_hs = (exp_h >= 96);
      if (bus_d.line_start === 1'b1) ls_cnt++;
      checks++; if (bus_d.h_count !== 10'(exp_h)) begin errors++; $display("FAIL ce_h i=%0d ce=%b actual=%0d required=%0d", i, ce, bus_d.h_count, exp_h); end
      checks++; if (bus_d.v_count !== 10'(exp_v)) begin errors++; $display("FAIL ce_v i=%0d ce=%b actual=%0d required=%0d", i, ce, bus_d.v_count, exp_v); end
      checks++; if (bus_d.hsync !== exp_hs) begin errors++; $display("FAIL ce_hsync i=%0d ce=%b actual=%b required=%b", i, ce, bus_d.hsync, exp_hs); end
      checks++; if (bus_d.line_start !== exp_ls) begin errors++; $display("FAIL ce_ls i=%0d ce=%b actual=%b required=%b", i, ce, bus_d.line_start, exp_ls); end
    end
    bus_d.pix_ce = 1'b0;
    checks++; if (ls_cnt != 1) begin errors++; $display("FAIL ce_ls_pulses actual=%0d required=1", ls_cnt); end
    checks++; if (bus_d.h_count !== 10'd0 || bus_d.v_count !== 10'd2) begin errors++; $display("FAIL ce_end_pos actual=(%0d,%0d) required=(0,2)", bus_d.h_count, bus_d.v_count); end
  endtask

  task automatic test_active_boundary();
    int   pos = 2 * 800;
    int   target = 35 * 800 + 145;
    int   h, v;
    logic exp_da;
    bus_d.pix_ce = 1'b1;
    while (pos < target) begin
      tick();
      pos++;
      h = pos % 800;
      v = pos / 800;
      exp_da = (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
      checks++; if (bus_d.h_count !== 10'(h) || bus_d.v_count !== 10'(v)) begin errors++; $display("FAIL bnd_pos actual=(%0d,%0d) required=(%0d,%0d)", bus_d.h_count, bus_d.v_count, h, v); end
      checks++; if (bus_d.display_active !== exp_da) begin errors++; $display("FAIL bnd_da at=(%0d,%0d) actual=%b required=%b", h, v, bus_d.display_active, exp_da); end
      checks++; if (bus_d.hsync !== (h >= 96)) begin errors++; $display("FAIL bnd_hsync at=(%0d,%0d) actual=%b", h, v, bus_d.hsync); end
      checks++; if (bus_d.vsync !== 1'b1) begin errors++; $display("FAIL bnd_vsync at=(%0d,%0d) actual=%b required=1", h, v, bus_d.vsync); end
    end
    bus_d.pix_ce = 1'b0;
  endtask

  task automatic test_frame();
    int   pos, h, v, exp_fc;
    int   fs_cnt = 0;
    int   vs_low = 0;
    int   da_cnt = 0;
    logic exp_hs, exp_vs, exp_da, exp_ls, exp_fs;
    bus_s.pix_ce = 1'b1;
    for (int i = 1; i <= S_FRAME; i++) begin
      tick();
      pos    = i % S_FRAME;
      h      = pos % S_HT;
      v      = pos / S_HT;
      exp_hs = (h >= S_HS);
      exp_vs = (v >= S_VS);
      exp_da = (h >= 6) && (h <= 13) && (v >= 2) && (v <= 3);
      exp_ls = (h == 0);
      exp_fs = (pos == 0);
      exp_fc = i / S_FRAME;
      if (bus_s.frame_start === 1'b1) fs_cnt++;
      if (bus_s.vsync === 1'b0) vs_low++;
      if (bus_s.display_active === 1'b1) da_cnt++;
      checks++; if (bus_s.h_count !== 10'(h) || bus_s.v_count !== 10'(v)) begin errors++; $display("FAIL frame_pos i=%0d actual=(%0d,%0d) required=(%0d,%0d)", i, bus_s.h_count, bus_s.v_count, h, v); end
      checks++; if (bus_s.hsync !== exp_hs) begin errors++; $display("FAIL frame_hsync at=(%0d,%0d) actual=%b required=%b", h, v, bus_s.hsync, exp_hs); end
      checks++; if (bus_s.vsync !== exp_vs) begin errors++; $display("FAIL frame_vsync at=(%0d,%0d) actual=%b required=%b", h, v, bus_s.vsync, exp_vs); end
      checks++; if (bus_s.display_active !== exp_da) begin errors++; $display("FAIL frame_da at=(%0d,%0d) actual=%b required=%b", h, v, bus_s.display_active, exp_da); end
      checks++; if (bus_s.line_start !== exp_ls) begin errors++; $display("FAIL frame_ls at=(%0d,%0d) actual=%b required=%b", h, v, bus_s.line_start, exp_ls); end
      checks++; if (bus_s.frame_start !== exp_fs) begin errors++; $display("FAIL frame_fs at=(%0d,%0d) actual=%b required=%b", h, v, bus_s.frame_start, exp_fs); end
      checks++; if (bus_s.frame_count !== 8'(exp_fc)) begin errors++; $display("FAIL frame_fc i=%0d actual=%0d required=%0d", i, bus_s.frame_count, exp_fc); end
    end
    checks++; if (fs_cnt != 1) begin errors++; $display("FAIL frame_fs_pulses actual=%0d required=1", fs_cnt); end
    checks++; if (vs_low != 16) begin errors++; $display("FAIL frame_vsync_low_cycles actual=%0d required=16", vs_low); end
    checks++; if (da_cnt != 16) begin errors++; $display("FAIL frame_da_cycles actual=%0d required=16", da_cnt); end
    bus_s.pix_ce = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus_s.pix_ce = 1'b1;
    for (int i = 0; i < 56; i++) tick();
    checks++; if (bus_s.h_count !== 10'd8 || bus_s.v_count !== 10'd3) begin errors++; $display("FAIL mid_pre_pos actual=(%0d,%0d) required=(8,3)", bus_s.h_count, bus_s.v_count); end
    checks++; if (bus_s.frame_count !== 8'd1) begin errors++; $display("FAIL mid_pre_fc actual=%0d required=1", bus_s.frame_count); end
    rst_s = 1'b1;
    tick();
    checks++; if (bus_s.h_count !== 10'd0 || bus_s.v_count !== 10'd0) begin errors++; $display("FAIL mid_rst_pos actual=(%0d,%0d) required=(0,0)", bus_s.h_count, bus_s.v_count); end
    checks++; if (bus_s.hsync !== 1'b0 || bus_s.vsync !== 1'b0) begin errors++; $display("FAIL mid_rst_sync actual=%b%b required=00", bus_s.hsync, bus_s.vsync); end
    checks++; if (bus_s.display_active !== 1'b0) begin errors++; $display("FAIL mid_rst_da actual=%b required=0", bus_s.display_active); end
    checks++; if (bus_s.line_start !== 1'b0 || bus_s.frame_start !== 1'b0) begin errors++; $display("FAIL mid_rst_pulse actual=%b%b required=00", bus_s.line_start, bus_s.frame_start); end
    checks++; if (bus_s.frame_count !== 8'd0) begin errors++; $display("FAIL mid_rst_fc actual=%0d required=0", bus_s.frame_count); end
    rst_s = 1'b0;
    bus_s.pix_ce = 1'b0;
    tick();
    checks++; if (bus_s.h_count !== 10'd0 || bus_s.frame_start !== 1'b0) begin errors++; $display("FAIL mid_post actual=h%0d fs%b required=h0 fs0", bus_s.h_count, bus_s.frame_start); end
  endtask

  task automatic test_frame_wrap();
    int   exp_fc;
    int   fs_cnt = 0;
    logic exp_fs;
    bus_s.pix_ce = 1'b1;
    for (int i = 1; i <= 256 * S_FRAME; i++) begin
      tick();
      exp_fs = ((i % S_FRAME) == 0);
      exp_fc = (i / S_FRAME) % 256;
      if (bus_s.frame_start === 1'b1) fs_cnt++;
      checks++; if (bus_s.frame_start !== exp_fs) begin errors++; $display("FAIL wrap_fs i=%0d actual=%b required=%b", i, bus_s.frame_start, exp_fs); end
      checks++; if (bus_s.frame_count !== 8'(exp_fc)) begin errors++; $display("FAIL wrap_fc i=%0d actual=%0d required=%0d", i, bus_s.frame_count, exp_fc); end
    end
    checks++; if (fs_cnt != 256) begin errors++; $display("FAIL wrap_fs_pulses actual=%0d required=256", fs_cnt); end
    checks++; if (bus_s.frame_count !== 8'd0 || bus_s.frame_start !== 1'b1) begin errors++; $display("FAIL wrap_final actual=fc%0d fs%b required=fc0 fs1", bus_s.frame_count, bus_s.frame_start); end
    bus_s.pix_ce = 1'b0;
  endtask

  initial begin
    bus_d.pix_ce = 1'b0;
    bus_s.pix_ce = 1'b0;
    test_reset();
    $display("test_reset done: errors=%0d", errors);
    test_line();
    $display("test_line done: errors=%0d", errors);
    test_ce_toggle();
    $display("test_ce_toggle done: errors=%0d", errors);
    test_active_boundary();
    $display("test_active_boundary done: errors=%0d", errors);
    test_frame();
    $display("test_frame done: errors=%0d", errors);
    test_reset_mid();
    $display("test_reset_mid done: errors=%0d", errors);
    test_frame_wrap();
    $display("test_frame_wrap done: errors=%0d", errors);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
